// File: rtl/mnist_pkg.sv
// mnist_pkg: constants and state encodings shared by the output-layer
// buffer loader and its shadow buffer.
//   N_OUT           : entries per frame (output neurons)
//   DATA_W          : IEEE-754 single word width
//   IDX_W           : write index width, ceil(log2(N_OUT))
//   PE_FINDAMX_LAT  : argmax pipeline latency of PE_findamx
//   HOLD_CYCLES_DEF : default presentation hold, tied to PE_FINDAMX_LAT
package mnist_pkg;

  localparam int N_OUT           = 10;
  localparam int DATA_W          = 32;
  localparam int IDX_W           = 4;
  localparam int PE_FINDAMX_LAT  = 8;
  localparam int HOLD_CYCLES_DEF = PE_FINDAMX_LAT;

  // Fill FSM: collecting beats, or holding a complete frame for transfer.
  localparam logic [0:0] FILL_ST = 1'b0;
  localparam logic [0:0] PEND_ST = 1'b1;

  // Present FSM: bank free, or bank held for the argmax pipeline.
  localparam logic [0:0] IDLE_ST = 1'b0;
  localparam logic [0:0] HOLD_ST = 1'b1;

  // A whole frame; element i is score i.
  typedef logic [N_OUT-1:0][DATA_W-1:0] frame_t;

endpackage

// File: rtl/ol_buf_loader_if.sv
// ol_buf_loader_if: serial valid/ready score stream feeding the loader.
//   in_valid : beat valid           (master -> slave)
//   in_data  : float32 score, opaque (master -> slave)
//   in_last  : final beat of frame  (master -> slave)
//   in_ready : slave accepts beat   (slave -> master)
interface ol_buf_loader_if;
  import mnist_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/ol_shadow_buf.sv
// ol_shadow_buf: N_OUT x DATA_W register file collecting one frame.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : write wr_data at wr_idx this edge
//   wr_idx   : entry to write (ignored when >= N_OUT)
//   wr_data  : word to store
//   rd_data  : all entries, read in parallel
module ol_shadow_buf
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output frame_t            rd_data
);

  frame_t mem_q, mem_d;

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_idx < IDX_W'(N_OUT))) mem_d[wr_idx] = wr_data;
  end

  // NOTE: this storage is reset on purpose: a frame presented after reset
  // must never expose stale scores, so it stays flops rather than a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/ol_buf_loader.sv
// ol_buf_loader: producer side of the PE_findamx output-layer buffer.
// Collects N_OUT serial scores into a shadow buffer, moves each complete
// frame into a presentation bank, holds it HOLD_CYCLES cycles and then
// pulses res_strobe. Framing errors discard the partial frame.
//   clk, rst      : clock, asynchronous active-high reset
//   in_if         : score stream (slave side)
//   out_0..out_9  : presented frame, to PE_findamx in_0..in_9
//   out_valid     : presented frame is being held
//   res_strobe    : one-cycle pulse, argmax of presented frame valid
//   frame_err     : one-cycle pulse, framing error, frame discarded
module ol_buf_loader
  import mnist_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ol_buf_loader_if.slave    in_if,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [DATA_W-1:0] out_4,
  output logic [DATA_W-1:0] out_5,
  output logic [DATA_W-1:0] out_6,
  output logic [DATA_W-1:0] out_7,
  output logic [DATA_W-1:0] out_8,
  output logic [DATA_W-1:0] out_9,
  output logic              out_valid,
  output logic              res_strobe,
  output logic              frame_err
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [0:0]        fill_q, fill_d;
  logic [0:0]        pres_q, pres_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  frame_t            out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              res_strobe_q, res_strobe_d;
  logic              frame_err_q, frame_err_d;
  logic              in_ready_q, in_ready_d;

  logic   accept;
  logic   transfer;
  frame_t shadow;

  // in_ready_q is only ever high while the fill FSM is in FILL.
  assign accept = in_if.in_valid && in_ready_q;

  ol_shadow_buf u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (wr_idx_q),
    .wr_data (in_if.in_data),
    .rd_data (shadow)
  );

  always_comb begin
    fill_d       = fill_q;
    pres_d       = pres_q;
    wr_idx_d     = wr_idx_q;
    hold_d       = hold_q;
    out_valid_d  = out_valid_q;
    res_strobe_d = 1'b0;
    frame_err_d  = 1'b0;
    transfer     = 1'b0;

    unique case (fill_q)
      FILL_ST: begin
        if (accept) begin
          if (wr_idx_q == IDX_W'(N_OUT - 1)) begin
            if (in_if.in_last) begin
              fill_d   = PEND_ST;
              wr_idx_d = wr_idx_q + IDX_W'(1);
            end else begin
              frame_err_d = 1'b1;  // missing last
              wr_idx_d    = '0;
            end
          end else if (in_if.in_last) begin
            frame_err_d = 1'b1;    // early last
            wr_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      PEND_ST: begin
        // The bank is free only once the present FSM is registered IDLE,
        // so a hold expiring this edge delays the transfer by one edge.
        if (pres_q == IDLE_ST) begin
          transfer = 1'b1;
          fill_d   = FILL_ST;
          wr_idx_d = '0;
        end
      end
      default: fill_d = FILL_ST;
    endcase

    unique case (pres_q)
      IDLE_ST: begin
        if (transfer) begin
          pres_d      = HOLD_ST;
          out_valid_d = 1'b1;
          hold_d      = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD_ST: begin
        if (hold_q == '0) begin
          pres_d       = IDLE_ST;
          out_valid_d  = 1'b0;
          res_strobe_d = 1'b1;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: pres_d = IDLE_ST;
    endcase

    out_d      = transfer ? shadow : out_q;
    in_ready_d = (fill_d == FILL_ST);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q       <= FILL_ST;
      pres_q       <= IDLE_ST;
      wr_idx_q     <= '0;
      hold_q       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      res_strobe_q <= 1'b0;
      frame_err_q  <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      pres_q       <= pres_d;
      wr_idx_q     <= wr_idx_d;
      hold_q       <= hold_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      res_strobe_q <= res_strobe_d;
      frame_err_q  <= frame_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign out_valid      = out_valid_q;
  assign res_strobe     = res_strobe_q;
  assign frame_err      = frame_err_q;

  assign out_0 = out_q[0];
  assign out_1 = out_q[1];
  assign out_2 = out_q[2];
  assign out_3 = out_q[3];
  assign out_4 = out_q[4];
  assign out_5 = out_q[5];
  assign out_6 = out_q[6];
  assign out_7 = out_q[7];
  assign out_8 = out_q[8];
  assign out_9 = out_q[9];

endmodule

// File: tb/tb_ol_buf_loader.sv
// tb_ol_buf_loader: randomized stimulus against a timestamp-based
// reference model of the loader (frame assembly from a queue, transfer and
// hold windows computed arithmetically from edge numbers).
module tb_ol_buf_loader;
  import mnist_pkg::*;

  localparam int HOLD = HOLD_CYCLES_DEF;
  localparam int FW   = N_OUT * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ol_buf_loader_if bus ();

  logic [DATA_W-1:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9;
  logic   out_valid, res_strobe, frame_err;
  frame_t dut_frame;
  assign dut_frame = {o9, o8, o7, o6, o5, o4, o3, o2, o1, o0};

  ol_buf_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .out_0      (o0), .out_1 (o1), .out_2 (o2), .out_3 (o3), .out_4 (o4),
    .out_5      (o5), .out_6 (o6), .out_7 (o7), .out_8 (o8), .out_9 (o9),
    .out_valid  (out_valid),
    .res_strobe (res_strobe),
    .frame_err  (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int argmax(input frame_t f);
    int     best = 0;
    shortreal bv = $bitstoshortreal(f[0]);
    for (int i = 1; i < N_OUT; i++)
      if ($bitstoshortreal(f[i]) > bv) begin
        bv   = $bitstoshortreal(f[i]);
        best = i;
      end
    return best;
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] part[$];   // beats of the frame being assembled
  bit     m_pend;               // a complete frame waits for the bank
  frame_t pend_frame;
  int     t_xfer;               // edge number of the pending transfer
  int     t_pres;               // edge number of the latest transfer
  frame_t pres_frame;
  bit     m_ready, m_accept;
  bit     e_ready, e_valid, e_strobe, e_err;
  int     edge_n = 0;

  task automatic model_clear();
    part.delete();
    m_pend     = 0;
    t_pres     = -1000;
    t_xfer     = 0;
    pres_frame = '0;
    m_ready    = 0;
    m_accept   = 0;
    e_ready    = 0;
    e_valid    = 0;
    e_strobe   = 0;
    e_err      = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      int k;
      bit err;
      k        = edge_n;
      edge_n   = edge_n + 1;
      err      = 0;
      m_accept = bus.in_valid && m_ready;
      if (m_pend && k == t_xfer) begin
        pres_frame = pend_frame;
        t_pres     = k;
        m_pend     = 0;
      end
      if (m_accept) begin
        part.push_back(bus.in_data);
        if (part.size() == N_OUT && bus.in_last) begin
          for (int i = 0; i < N_OUT; i++) pend_frame[i] = part[i];
          m_pend = 1;
          // Next edge, but never before the edge after the current hold expires.
          t_xfer = (k + 1 > t_pres + HOLD + 1) ? k + 1 : t_pres + HOLD + 1;
          part.delete();
        end else if (bus.in_last || part.size() == N_OUT) begin
          err = 1;
          part.delete();
        end
      end
      m_ready  = !m_pend;
      e_ready  = m_ready;
      e_valid  = (k >= t_pres) && (k < t_pres + HOLD);
      e_strobe = (k == t_pres + HOLD);
      e_err    = err;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("in_ready",   bus.in_ready, e_ready);
    check("out_valid",  out_valid,    e_valid);
    check("res_strobe", res_strobe,   e_strobe);
    check("frame_err",  frame_err,    e_err);
    check("out_frame",  dut_frame,    pres_frame);
    if (e_strobe) check("argmax", argmax(dut_frame), argmax(pres_frame));
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input frame_t f, input int last_pos, input int nbeats, input int duty);
    for (int i = 0; i < nbeats; i++) begin
      int wait_n = 0;
      while ($urandom_range(1, 100) > duty) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      bus.in_last  = (i == last_pos);
      do begin
        @(posedge clk); #1;
        wait_n++;
      end while (!m_accept && wait_n < 300);
      if (!m_accept) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_pend || edge_n <= t_pres + HOLD + 1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_out_frame",  dut_frame,    '0);
    check("rst_in_ready",   bus.in_ready, 1'b0);
    check("rst_out_valid",  out_valid,    1'b0);
    check("rst_res_strobe", res_strobe,   1'b0);
    check("rst_frame_err",  frame_err,    1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N_OUT; i++)
      f[i] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    return f;
  endfunction

  frame_t f1, f2, f3;

  initial begin
    model_clear();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    f1 = {32'h42C80000, 32'h42B40000, 32'h42A00000, 32'h428C0000, 32'h42700000,
          32'h42480000, 32'h42200000, 32'h41F00000, 32'h41A00000, 32'h41200000};
    f2    = f1;
    f2[8] = 32'h42C80000;
    f2[9] = 32'h42B40000;
    for (int i = 0; i < N_OUT; i++) f3[i] = f1[N_OUT - 1 - i];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Clean frame, back-to-back beats: argmax 9.
    send_frame(f1, N_OUT - 1, N_OUT, 100);
    check("s1_argmax_const", argmax(f1), 9);
    drain();

    // Two frames streamed back to back: backpressure during first hold.
    send_frame(f1, N_OUT - 1, N_OUT, 100);
    send_frame(f2, N_OUT - 1, N_OUT, 100);
    drain();

    // Early last on beat 4, then a clean frame with max at index 0.
    send_frame(f1, 3, 4, 100);
    send_frame(f3, N_OUT - 1, N_OUT, 100);
    drain();

    // Ten beats without in_last, then recovery.
    send_frame(rand_frame(), -1, N_OUT, 100);
    repeat (3) @(posedge clk);
    #1;
    send_frame(f1, N_OUT - 1, N_OUT, 100);
    drain();

    // Five random frames with ~50% valid duty.
    for (int n = 0; n < 5; n++) send_frame(rand_frame(), N_OUT - 1, N_OUT, 50);
    drain();

    // Reset at beat 6, then a full frame, reset during its hold, then clean.
    send_frame(f1, -1, 6, 100);
    do_reset();
    send_frame(f1, N_OUT - 1, N_OUT, 100);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    send_frame(f1, N_OUT - 1, N_OUT, 100);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
